pwl_activation: RTL and testbench

Parametrised, pipelined piecewise-linear activation unit for the fixed-point datapath. It evaluates a runtime-programmable segment table (threshold, x offset, power-of-two slope, bias, flat flag) per sample. Optionally it evaluates sigmoid via the tanh identity sigmoid(x) = 0.5·tanh(x/2) + 0.5. It sits between MAC accumulators and the activation writeback, with valid/ready on both sides.

---
 rtl/pwl_pkg.sv | 54 +++++
 rtl/pwl_seg_lut.sv | 54 +++++
 rtl/pwl_activation.sv | 197 +++++++++++++++++++
 tb/tb_pwl_activation.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwl_pkg.sv
// pwl_pkg: shared types, default widths and the saturate helper for the
// piecewise-linear activation unit. The entry struct and the saturate
// helper are sized by the constants below.
package pwl_pkg;

    localparam int PWL_DATA_W  = 16;
    localparam int PWL_FRAC_W  = 8;
    localparam int PWL_SEG_N   = 64;
    localparam int PWL_SHIFT_W = 3;
    localparam int PWL_BIAS_W  = 10;

    typedef enum logic {
        MODE_TANH    = 1'b0,
        MODE_SIGMOID = 1'b1
    } pwl_mode_e;

    typedef struct packed {
        logic [PWL_DATA_W-1:0]  thresh;
        logic [PWL_DATA_W-1:0]  xoff;
        logic [PWL_SHIFT_W-1:0] shift;
        logic [PWL_BIAS_W-1:0]  bias;
        logic                   flat;
    } pwl_entry_t;

    // Entry contents after reset: never selected by threshold below the
    // maximum, flat with zero bias, so an unprogrammed table yields 0.
    function automatic pwl_entry_t pwl_default_entry();
        pwl_entry_t e;
        e.thresh = {1'b0, {(PWL_DATA_W-1){1'b1}}};
        e.xoff   = {PWL_DATA_W{1'b0}};
        e.shift  = {PWL_SHIFT_W{1'b0}};
        e.bias   = {PWL_BIAS_W{1'b0}};
        e.flat   = 1'b1;
        return e;
    endfunction

    // Clamp a DATA_W+2 bit signed value into the DATA_W signed range.
    function automatic logic [PWL_DATA_W-1:0] pwl_sat(input logic signed [PWL_DATA_W+1:0] v);
        logic signed [PWL_DATA_W+1:0] max_v;
        logic signed [PWL_DATA_W+1:0] min_v;
        logic [PWL_DATA_W-1:0]        r;
        max_v = {3'b000, {(PWL_DATA_W-1){1'b1}}};
        min_v = {3'b111, {(PWL_DATA_W-1){1'b0}}};
        if (v > max_v) begin
            r = max_v[PWL_DATA_W-1:0];
        end else if (v < min_v) begin
            r = min_v[PWL_DATA_W-1:0];
        end else begin
            r = v[PWL_DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pwl_seg_lut.sv
// pwl_seg_lut: segment table storage with a single write port and a
// parallel signed compare + priority select. Entry 0 is the catch-all;
// among matching entries the highest index wins, which for an ascending
// table is the segment containing x.
module pwl_seg_lut
    import pwl_pkg::*;
#(
    parameter int SEG_N  = PWL_SEG_N,
    parameter int ADDR_W = $clog2(SEG_N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  pwl_entry_t            wr_entry,
    input  logic [PWL_DATA_W-1:0] x,
    output pwl_entry_t            sel_entry
);

    pwl_entry_t        table_r [SEG_N];
    logic [SEG_N-1:0]  hit_s;
    logic [ADDR_W-1:0] sel_idx_s;

    // Table storage: default entries on reset, one entry written per accepted write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SEG_N; i++) begin
                table_r[i] <= pwl_default_entry();
            end
        end else if (wr_en) begin
            table_r[wr_addr] <= wr_entry;
        end
    end

    // Signed compare of x against every lower bound; entry 0 always matches.
    always_comb begin
        hit_s    = {SEG_N{1'b0}};
        hit_s[0] = 1'b1;
        for (int i = 1; i < SEG_N; i++) begin
            hit_s[i] = ($signed(x) >= $signed(table_r[i].thresh));
        end
    end

    // Priority encode: the highest matching index is selected.
    always_comb begin
        sel_idx_s = {ADDR_W{1'b0}};
        for (int i = 0; i < SEG_N; i++) begin
            sel_idx_s = hit_s[i] ? ADDR_W'(i) : sel_idx_s;
        end
    end

    assign sel_entry = table_r[sel_idx_s];

endmodule

// File: rtl/pwl_activation.sv
// pwl_activation: 3-stage pipelined piecewise-linear activation with
// valid/ready on both sides and a runtime-programmable segment table.
// Optional feature macro: PWL_SIGMOID_EN -- when defined, in_mode selects
// sigmoid evaluation through the tanh table (x/2 pre-scale, t/2 + 0.5
// post-scale); when undefined every sample is evaluated in table mode.
module pwl_activation
    import pwl_pkg::*;
#(
    parameter int DATA_W  = PWL_DATA_W,
    parameter int FRAC_W  = PWL_FRAC_W,
    parameter int SEG_N   = PWL_SEG_N,
    parameter int SHIFT_W = PWL_SHIFT_W,
    parameter int BIAS_W  = PWL_BIAS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     cfg_we,
    output logic                     cfg_ready,
    input  logic [$clog2(SEG_N)-1:0] cfg_addr,
    input  logic [DATA_W-1:0]        cfg_thresh,
    input  logic [DATA_W-1:0]        cfg_xoff,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic [BIAS_W-1:0]        cfg_bias,
    input  logic                     cfg_flat
);

    logic                     en_s;
    logic                     acc_s;
    logic                     cfg_wr_s;
    pwl_entry_t               cfg_entry_s;
    pwl_entry_t               sel_entry_s;
    logic [DATA_W-1:0]        x_pre_s;
    logic [DATA_W-1:0]        unused_thresh_s;

    logic                     v1_r;
    logic [DATA_W-1:0]        x1_r;

    logic                     v2_r;
    logic [DATA_W:0]          dx2_r;
    logic [SHIFT_W-1:0]       shift2_r;
    logic [BIAS_W-1:0]        bias2_r;
    logic                     flat2_r;

    logic                     out_valid_r;
    logic [DATA_W-1:0]        out_data_r;

    logic [DATA_W:0]          dx_s;
    logic signed [DATA_W:0]   shifted_s;
    logic signed [DATA_W+1:0] sum_s;
    logic [DATA_W-1:0]        bias_ext_s;
    logic [DATA_W-1:0]        tab_s;
    logic [DATA_W-1:0]        y_s;

    // Every stage advances together whenever the output slot is free or draining.
    assign en_s      = ~out_valid_r | out_ready;
    assign in_ready  = en_s & ~cfg_we;
    assign acc_s     = in_valid & in_ready;
    // Table writes wait until no sample is in flight so a sample never sees a half-updated table.
    assign cfg_ready = ~(v1_r | v2_r | out_valid_r);
    assign cfg_wr_s  = cfg_we & cfg_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // Pack the configuration port into a table entry.
    always_comb begin
        cfg_entry_s        = pwl_default_entry();
        cfg_entry_s.thresh = cfg_thresh;
        cfg_entry_s.xoff   = cfg_xoff;
        cfg_entry_s.shift  = cfg_shift;
        cfg_entry_s.bias   = cfg_bias;
        cfg_entry_s.flat   = cfg_flat;
    end

    pwl_seg_lut #(
        .SEG_N (SEG_N)
    ) u_lut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (cfg_wr_s),
        .wr_addr   (cfg_addr),
        .wr_entry  (cfg_entry_s),
        .x         (x1_r),
        .sel_entry (sel_entry_s)
    );

    // The lookup result's lower bound is only needed inside the table.
    assign unused_thresh_s = sel_entry_s.thresh;

`ifdef PWL_SIGMOID_EN
    localparam logic signed [DATA_W+1:0] HALF_C = {{(DATA_W+1){1'b0}}, 1'b1} << (FRAC_W-1);

    pwl_mode_e m1_r;
    pwl_mode_e m2_r;

    // Sigmoid samples are halved before lookup; table samples pass through.
    always_comb begin
        if (pwl_mode_e'(in_mode) == MODE_SIGMOID) begin
            x_pre_s = $signed(in_data) >>> 1;
        end else begin
            x_pre_s = in_data;
        end
    end

    // Mode travels with its sample through stages 1 and 2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m1_r <= MODE_TANH;
            m2_r <= MODE_TANH;
        end else if (en_s) begin
            m1_r <= pwl_mode_e'(in_mode);
            m2_r <= m1_r;
        end
    end

    // Sigmoid post-scale: y = t/2 + 0.5, saturated.
    always_comb begin
        if (m2_r == MODE_SIGMOID) begin
            y_s = pwl_sat(($signed({{2{tab_s[DATA_W-1]}}, tab_s}) >>> 1) + HALF_C);
        end else begin
            y_s = tab_s;
        end
    end
`else
    logic [1:0] unused_mode_s;

    assign x_pre_s       = in_data;
    assign y_s           = tab_s;
    assign unused_mode_s = {in_mode, 1'(FRAC_W)};
`endif

    // Stage 1: capture the accepted (pre-scaled) sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_r <= 1'b0;
            x1_r <= {DATA_W{1'b0}};
        end else if (en_s) begin
            v1_r <= acc_s;
            x1_r <= x_pre_s;
        end
    end

    // Offset subtraction on the selected segment, one bit wider so it cannot wrap.
    always_comb begin
        dx_s = {x1_r[DATA_W-1], x1_r} - {sel_entry_s.xoff[DATA_W-1], sel_entry_s.xoff};
    end

    // Stage 2: register the segment parameters and the offset difference.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v2_r     <= 1'b0;
            dx2_r    <= {(DATA_W+1){1'b0}};
            shift2_r <= {SHIFT_W{1'b0}};
            bias2_r  <= {BIAS_W{1'b0}};
            flat2_r  <= 1'b1;
        end else if (en_s) begin
            v2_r     <= v1_r;
            dx2_r    <= dx_s;
            shift2_r <= sel_entry_s.shift;
            bias2_r  <= sel_entry_s.bias;
            flat2_r  <= sel_entry_s.flat;
        end
    end

    // Slope shift, bias add and saturation; flat segments emit the bias alone.
    always_comb begin
        shifted_s  = $signed(dx2_r) >>> shift2_r;
        sum_s      = $signed({{(DATA_W+2-BIAS_W){bias2_r[BIAS_W-1]}}, bias2_r})
                   + $signed({shifted_s[DATA_W], shifted_s});
        bias_ext_s = {{(DATA_W-BIAS_W){bias2_r[BIAS_W-1]}}, bias2_r};
        if (flat2_r) begin
            tab_s = bias_ext_s;
        end else begin
            tab_s = pwl_sat(sum_s);
        end
    end

    // Stage 3: output register; data only changes when a valid result moves in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else if (en_s) begin
            out_valid_r <= v2_r;
            if (v2_r) begin
                out_data_r <= y_s;
            end
        end
    end

endmodule

// File: tb/tb_pwl_activation.sv
// tb_pwl_activation: directed and randomized checks of pwl_activation
// against a behavioural segment-table model and a scoreboard queue.
module tb_pwl_activation;

    localparam int DW   = 16;
    localparam int SEGS = 64;
    localparam int AW   = 6;
`ifdef PWL_SIGMOID_EN
    localparam bit SIG = 1'b1;
`else
    localparam bit SIG = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          in_valid   = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data    = 16'h0000;
    logic          in_mode    = 1'b0;
    logic          out_valid;
    logic          out_ready  = 1'b1;
    logic [DW-1:0] out_data;
    logic          cfg_we     = 1'b0;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr   = 6'd0;
    logic [DW-1:0] cfg_thresh = 16'h0000;
    logic [DW-1:0] cfg_xoff   = 16'h0000;
    logic [2:0]    cfg_shift  = 3'd0;
    logic [9:0]    cfg_bias   = 10'h000;
    logic          cfg_flat   = 1'b0;

    int checks = 0;
    int errors = 0;
    int popped = 0;
    int in_ready_low_cnt = 0;

    int m_thr   [SEGS];
    int m_xoff  [SEGS];
    int m_shift [SEGS];
    int m_bias  [SEGS];
    int m_flat  [SEGS];
    int exp_q   [$];

    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = 16'h0000;
    logic          drv_done   = 1'b0;

    pwl_activation dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_thresh (cfg_thresh),
        .cfg_xoff   (cfg_xoff),
        .cfg_shift  (cfg_shift),
        .cfg_bias   (cfg_bias),
        .cfg_flat   (cfg_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < SEGS; i++) begin
            m_thr[i] = 32767; m_xoff[i] = 0; m_shift[i] = 0; m_bias[i] = 0; m_flat[i] = 1;
        end
    endfunction

    // Expected output from the arithmetic definition of the activation.
    function automatic int model(input int x, input bit m);
        int xv, idx, t;
        xv = x;
        if (SIG && m) xv = xv >>> 1;
        idx = 0;
        for (int i = 1; i < SEGS; i++) if (xv >= m_thr[i]) idx = i;
        if (m_flat[idx] != 0) t = m_bias[idx];
        else t = sat16(m_bias[idx] + ((xv - m_xoff[idx]) >>> m_shift[idx]));
        if (SIG && m) t = sat16((t >>> 1) + 128);
        return t & 32'h0000FFFF;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            model_reset();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, stall_data);
            end
            check("in_ready_rule", in_ready, (!out_valid || out_ready) && !cfg_we);
            check("cfg_ready_empty", cfg_ready, exp_q.size() == 0);
            if (!in_ready && !cfg_we) in_ready_low_cnt++;
            if (cfg_we && cfg_ready) begin
                m_thr[cfg_addr]   = int'($signed(cfg_thresh));
                m_xoff[cfg_addr]  = int'($signed(cfg_xoff));
                m_shift[cfg_addr] = int'(cfg_shift);
                m_bias[cfg_addr]  = int'($signed(cfg_bias));
                m_flat[cfg_addr]  = int'(cfg_flat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                    popped++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(int'($signed(in_data)), in_mode));
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic do_reset();
        in_valid = 1'b0; cfg_we = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_cfg_ready"}, cfg_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [DW-1:0] x, input logic m);
        int n;
        in_valid = 1'b1; in_data = x; in_mode = m;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("push_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input int a, input logic [DW-1:0] th, input logic [DW-1:0] xo,
                             input logic [2:0] sh, input logic [9:0] b, input logic fl, output int n);
        cfg_addr = AW'(a); cfg_thresh = th; cfg_xoff = xo; cfg_shift = sh; cfg_bias = b; cfg_flat = fl;
        cfg_we = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("cfg_timeout", 1, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic directed(input logic [DW-1:0] x, input logic m, input logic [31:0] exp, input string name);
        int lat;
        push(x, m);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
        check({name, "_latency"}, lat, 3);
        check(name, out_data, exp);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, p0, l0, thr;
        do_reset();
        reset_checks("reset");

        // Unprogrammed table evaluates to zero.
        directed(16'h0080, 1'b0, 32'h0000, "post_reset_0080");
        directed(16'hF000, 1'b0, 32'h0000, "post_reset_F000");
        directed(16'h7FFF, 1'b0, 32'h0000, "post_reset_7FFF");

        // Hard-tanh table.
        cfg_write(0, 16'h0000, 16'h0000, 3'd0, 10'h300, 1'b1, n);
        cfg_write(1, 16'hFF00, 16'h0000, 3'd0, 10'h000, 1'b0, n);
        cfg_write(2, 16'h0100, 16'h0000, 3'd0, 10'h100, 1'b1, n);
        directed(16'h0080, 1'b0, 32'h0080, "htanh_linear");
        directed(16'hF000, 1'b0, 32'hFF00, "htanh_low");
        directed(16'h0400, 1'b0, 32'h0100, "htanh_high");

        // Reset with samples in flight and the output stalled.
        out_ready = 1'b0;
        push(16'h0080, 1'b0);
        push(16'h0400, 1'b0);
        do_reset();
        out_ready = 1'b1;
        reset_checks("midreset");
        directed(16'h0400, 1'b0, 32'h0000, "midreset_default_table");

        // Saturation: the top entry catches 0x7FFF, entry 0 catches the rest.
        cfg_write(0, 16'h0000, 16'h8000, 3'd0, 10'h100, 1'b0, n);
        cfg_write(63, 16'h7FFF, 16'h8000, 3'd0, 10'h100, 1'b0, n);
        directed(16'h7FFF, 1'b0, 32'h7FFF, "sat_pos");
        directed(16'h8000, 1'b0, 32'h0100, "sat_min_x");

        // Identity table, sigmoid and interleaved modes.
        do_reset();
        cfg_write(0, 16'h0000, 16'h0000, 3'd0, 10'h000, 1'b0, n);
        directed(16'h0000, 1'b1, SIG ? 32'h0080 : 32'h0000, "sig_zero");
        directed(16'h0100, 1'b1, SIG ? 32'h00C0 : 32'h0100, "sig_one");
        directed(16'h0100, 1'b0, 32'h0100, "tanh_interleaved");
        for (int i = 0; i < 6; i++) push(16'h0040 * i, i[0]);
        drain();

        // Backpressure: 8 back-to-back samples, output stalled for 5 cycles.
        p0 = popped; l0 = in_ready_low_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) push(16'h0100 + 16'h0123 * i, 1'b0);
            end
            begin
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_output_count", popped - p0, 8);
        check("bp_in_ready_dropped", in_ready_low_cnt > l0, 1);

        // Config write raised with two samples in flight.
        push(16'h0100, 1'b0);
        push(16'h0200, 1'b0);
        cfg_write(0, 16'h0000, 16'h0000, 3'd1, 10'h040, 1'b0, n);
        check("cfg_wait_cycles", n, 3);
        directed(16'h0100, 1'b0, 32'h00C0, "cfg_new_entry");

        // Randomized table and traffic with random backpressure.
        do_reset();
        cfg_write(0, 16'h0000, 16'($urandom), 3'($urandom), 10'($urandom), ($urandom_range(0, 3) == 0), n);
        for (int i = 1; i < SEGS; i++) begin
            thr = -32768 + i * 1000 + int'($urandom_range(0, 900));
            cfg_write(i, 16'(thr), 16'($urandom), 3'($urandom), 10'($urandom), ($urandom_range(0, 3) == 0), n);
        end
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    push(16'($urandom), 1'($urandom_range(0, 1)));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
